// File: rtl/fu_wb_arbiter.sv
// Writeback arbiter: per-unit result FIFOs merged onto one scoreboard port.
// Round-robin or fixed-priority grant, held stable while the port stalls.
module fu_wb_arbiter #(
  parameter int NR_CH      = 4,
  parameter int DEPTH      = 2,
  parameter int DATA_W     = 64,
  parameter int TRANS_ID_W = 3,
  parameter bit RR_EN      = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic [NR_CH-1:0]           in_valid_i,
  output logic [NR_CH-1:0]           in_ready_o,
  input  logic [NR_CH*DATA_W-1:0]    in_data_i,
  input  logic [NR_CH*TRANS_ID_W-1:0] in_trans_id_i,
  input  logic [NR_CH-1:0]           in_ex_valid_i,
  input  logic [NR_CH*64-1:0]        in_ex_cause_i,
  output logic                       wb_valid_o,
  input  logic                       wb_ready_i,
  output logic [DATA_W-1:0]          wb_data_o,
  output logic [TRANS_ID_W-1:0]      wb_trans_id_o,
  output logic                       wb_ex_valid_o,
  output logic [63:0]                wb_ex_cause_o,
  output logic [$clog2(NR_CH)-1:0]   wb_ch_o
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int CHW = $clog2(NR_CH);
  localparam int EW  = DATA_W + TRANS_ID_W + 65;

  logic [NR_CH-1:0] nonempty;
  logic [EW-1:0]    head [NR_CH];
  logic [EW-1:0]    sel;
  logic [CHW-1:0]   grant;
  logic [CHW-1:0]   lock_ch;
  logic [CHW-1:0]   rr_ptr;
  logic             locked;
  logic             any;
  logic             fire;
  logic             found;
  int               idx;

  assign any  = |nonempty;
  assign fire = any & wb_ready_i;

  for (genvar c = 0; c < NR_CH; c++) begin : g_ch
    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          push;
    logic          pop;

    assign in_ready_o[c] = cnt < CW'(DEPTH);
    assign push = in_valid_i[c] & in_ready_o[c]
                & ~flush_i & ~rst_i;
    assign pop  = fire & (grant == CHW'(c)) & ~flush_i;
    assign nonempty[c] = cnt != '0;
    assign head[c] = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        cnt <= cnt + CW'(push) - CW'(pop);
      end
    end

    always_ff @(posedge clk_i) begin
      if (push) begin
        mem[wr_ptr] <= {in_data_i[c*DATA_W +: DATA_W],
                        in_trans_id_i[c*TRANS_ID_W +: TRANS_ID_W],
                        in_ex_valid_i[c],
                        in_ex_cause_i[c*64 +: 64]};
      end
    end
  end

  // A stalled grant stays put; otherwise scan from rr_ptr (or from 0).
  always_comb begin
    grant = lock_ch;
    found = locked;
    idx   = 0;
    for (int i = 0; i < NR_CH; i++) begin
      idx = RR_EN ? (int'(rr_ptr) + i) % NR_CH : i;
      if (!found && nonempty[CHW'(idx)]) begin
        grant = CHW'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      locked  <= 1'b0;
      lock_ch <= '0;
      rr_ptr  <= '0;
    end else if (flush_i) begin
      locked <= 1'b0;
    end else begin
      locked  <= any & ~wb_ready_i;
      lock_ch <= grant;
      if (fire && RR_EN) begin
        rr_ptr <= (grant == CHW'(NR_CH - 1)) ? '0 : grant + 1'b1;
      end
    end
  end

  assign sel           = head[grant];
  assign wb_valid_o    = any;
  assign wb_data_o     = any ? sel[EW-1 -: DATA_W] : '0;
  assign wb_trans_id_o = any ? sel[65 +: TRANS_ID_W] : '0;
  assign wb_ex_valid_o = any & sel[64];
  assign wb_ex_cause_o = any ? sel[63:0] : '0;
  assign wb_ch_o       = any ? grant : '0;

endmodule
